clk_div_ctrl: RTL and testbench

- Run-controlled, reprogrammable divider that produces the slow clock `clk_N` and a one-cycle `tick` strobe for the display and counter logic.
- Host logic (key debounce or mode FSM) can start, pause, single-step, stop and retune the divider without glitching the divided output.
- Divisor changes requested while running take effect only on a half-period boundary.
- Sits between the board clock and all slow-rate consumers in the design.

---
 rtl/clk_div_ctrl_if.sv | 23 ++
 rtl/clk_div_ctrl.sv | 105 ++++++++++
 tb/tb_clk_div_ctrl.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/clk_div_ctrl_if.sv
// Host-side command and divisor-configuration bundle for clk_div_ctrl.
// The host drives commands and offers divisors; the divider returns cfg_ready.
interface clk_div_ctrl_if #(
    parameter int unsigned WIDTH = 32
);
    logic             cmd_run;
    logic             cmd_pause;
    logic             cmd_step;
    logic             cmd_stop;
    logic             cfg_valid;
    logic [WIDTH-1:0] cfg_div;
    logic             cfg_ready;

    modport master (
        output cmd_run, cmd_pause, cmd_step, cmd_stop, cfg_valid, cfg_div,
        input  cfg_ready
    );

    modport slave (
        input  cmd_run, cmd_pause, cmd_step, cmd_stop, cfg_valid, cfg_div,
        output cfg_ready
    );
endinterface

// File: rtl/clk_div_ctrl.sv
// Run-controlled, reprogrammable half-period divider producing clk_N and a
// registered tick strobe aligned with each clk_N rising edge.
module clk_div_ctrl #(
    parameter int unsigned WIDTH       = 32,
    parameter int unsigned DEFAULT_DIV = 50_000_000
) (
    input  logic              clk,
    input  logic              rst_n,
    clk_div_ctrl_if.slave     bus,
    output logic              clk_N,
    output logic              tick,
    output logic [1:0]        state,
    output logic              busy
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        STEP  = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] cnt, div_q, div_p;
    logic             pend;
    logic             counting, boundary, apply_pend, accept;

    assign counting   = (state_q == RUN) || (state_q == STEP);
    // A stop in the same cycle suppresses the boundary entirely.
    assign boundary   = counting && !bus.cmd_stop && (cnt == div_q - WIDTH'(1));
    assign apply_pend = pend && (!counting || boundary);
    assign accept     = bus.cfg_valid && !pend;

    assign bus.cfg_ready = !pend;
    assign state         = state_q;
    assign busy          = counting;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (bus.cmd_stop)      state_d = IDLE;
                else if (bus.cmd_run)  state_d = RUN;
                else if (bus.cmd_step) state_d = STEP;
            end
            RUN: begin
                if (bus.cmd_stop)       state_d = IDLE;
                else if (bus.cmd_pause) state_d = PAUSE;
            end
            PAUSE: begin
                if (bus.cmd_stop)      state_d = IDLE;
                else if (bus.cmd_run)  state_d = RUN;
                else if (bus.cmd_step) state_d = STEP;
            end
            STEP: begin
                if (bus.cmd_stop)       state_d = IDLE;
                else if (bus.cmd_pause) state_d = PAUSE;
                else if (bus.cmd_run)   state_d = RUN;
                else if (boundary)      state_d = PAUSE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt   <= '0;
            div_q <= WIDTH'(DEFAULT_DIV);
            div_p <= '0;
            pend  <= 1'b0;
            clk_N <= 1'b0;
            tick  <= 1'b0;
        end else begin
            tick <= 1'b0;
            if (bus.cmd_stop) begin
                cnt   <= '0;
                clk_N <= 1'b0;
            end else if (boundary) begin
                cnt   <= '0;
                clk_N <= ~clk_N;
                tick  <= ~clk_N;
            end else if (counting) begin
                cnt <= cnt + WIDTH'(1);
            end else if (pend) begin
                // Retune while idle/paused restarts a full-length half-period.
                cnt <= '0;
            end

            if (apply_pend) begin
                div_q <= div_p;
                pend  <= 1'b0;
            end else if (accept) begin
                div_p <= (bus.cfg_div == '0) ? WIDTH'(1) : bus.cfg_div;
                pend  <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_clk_div_ctrl.sv
// Scoreboard bench for clk_div_ctrl: stimulus queues cycle-stamped expected
// output snapshots, a negedge monitor pops and compares them.
module tb_clk_div_ctrl;
    localparam int W = 32;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       clk_N, tick, busy;
    logic [1:0] state;

    clk_div_ctrl_if #(.WIDTH(W)) ifc ();

    clk_div_ctrl #(.WIDTH(W), .DEFAULT_DIV(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifc),
        .clk_N (clk_N),
        .tick  (tick),
        .state (state),
        .busy  (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         cyc;
        string      tag;
        logic       cn;
        logic       tk;
        logic [1:0] st;
        logic       rdy;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   cyc    = 0;
    int   n_cmp  = 0;
    int   n_bad  = 0;
    bit   mon_en = 1'b0;
    logic prev_cn = 1'b0;
    logic exp_busy;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void push(input int at, input string tag, input logic cn,
                                 input logic tk, input logic [1:0] st, input logic rdy);
        exp_t x;
        x.cyc = at; x.tag = tag; x.cn = cn; x.tk = tk; x.st = st; x.rdy = rdy;
        sb.push_back(x);
    endfunction

    task automatic wait_cyc(input int n);
        while (cyc < n) @(negedge clk);
    endtask

    // Monitor: compare snapshot when one is due; otherwise any clk_N change or tick is unexpected.
    always @(negedge clk) begin
        if (mon_en) begin
            while (sb.size() > 0 && sb[0].cyc < cyc) begin
                e = sb.pop_front();
                n_cmp++; n_bad++;
                $display("FAIL %s: snapshot for cyc %0d not taken (now %0d)", e.tag, e.cyc, cyc);
            end
            if (sb.size() > 0 && sb[0].cyc == cyc) begin
                e = sb.pop_front();
                exp_busy = (e.st == 2'd1) || (e.st == 2'd3);
                n_cmp++;
                if ({clk_N, tick, state, ifc.cfg_ready, busy} !== {e.cn, e.tk, e.st, e.rdy, exp_busy}) begin
                    n_bad++;
                    $display("FAIL %s @cyc %0d: got clk_N=%b tick=%b state=%0d ready=%b busy=%b, want clk_N=%b tick=%b state=%0d ready=%b busy=%b",
                             e.tag, cyc, clk_N, tick, state, ifc.cfg_ready, busy,
                             e.cn, e.tk, e.st, e.rdy, exp_busy);
                end
            end else if (clk_N !== prev_cn || tick !== 1'b0) begin
                n_cmp++; n_bad++;
                $display("FAIL unexpected_edge @cyc %0d: got clk_N=%b (was %b) tick=%b, want no change and tick=0",
                         cyc, clk_N, prev_cn, tick);
            end
        end
        prev_cn = clk_N;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        ifc.cmd_run = 0; ifc.cmd_pause = 0; ifc.cmd_step = 0; ifc.cmd_stop = 0;
        ifc.cfg_valid = 0; ifc.cfg_div = '0;

        // Reset values while rst_n is low
        wait_cyc(2);
        push(3, "reset", 0, 0, 2'd0, 1);
        mon_en = 1'b1;
        wait_cyc(3); rst_n = 1'b1;

        // Run with default div 4: toggles every 4 RUN cycles
        wait_cyc(4); ifc.cmd_run = 1;
        push(5,  "run_entry", 0, 0, 2'd1, 1);
        push(9,  "rise1",     1, 1, 2'd1, 1);
        push(13, "fall1",     0, 0, 2'd1, 1);
        push(17, "rise2",     1, 1, 2'd1, 1);
        push(21, "fall2",     0, 0, 2'd1, 1);
        wait_cyc(5); ifc.cmd_run = 0;

        // Pause with frozen count 2 for 10 cycles, then resume
        wait_cyc(22); ifc.cmd_pause = 1;
        push(23, "pause_entry", 0, 0, 2'd2, 1);
        push(31, "pause_hold",  0, 0, 2'd2, 1);
        wait_cyc(32); ifc.cmd_pause = 0; ifc.cmd_run = 1;
        push(33, "resume",      0, 0, 2'd1, 1);
        push(35, "resume_rise", 1, 1, 2'd1, 1);
        push(39, "resume_fall", 0, 0, 2'd1, 1);
        wait_cyc(33); ifc.cmd_run = 0;

        // Pause landing on a boundary, then single step
        wait_cyc(42); ifc.cmd_pause = 1;
        push(43, "pause_on_boundary", 1, 1, 2'd2, 1);
        wait_cyc(43); ifc.cmd_pause = 0;
        wait_cyc(46); ifc.cmd_step = 1;
        push(47, "step_entry", 1, 0, 2'd3, 1);
        push(51, "step_done",  0, 0, 2'd2, 1);
        push(71, "step_quiet", 0, 0, 2'd2, 1);
        wait_cyc(47); ifc.cmd_step = 0;

        // Retune 4 -> 2 mid half-period
        wait_cyc(72); ifc.cmd_run = 1;
        push(73, "cfg_run",      0, 0, 2'd1, 1);
        push(77, "cfg_rise",     1, 1, 2'd1, 1);
        push(79, "cfg_pending",  1, 0, 2'd1, 0);
        push(81, "cfg_applied",  0, 0, 2'd1, 1);
        push(83, "div2_rise",    1, 1, 2'd1, 1);
        push(85, "div2_fall",    0, 0, 2'd1, 1);
        push(87, "div2_rise2",   1, 1, 2'd1, 1);
        push(89, "div2_fall2",   0, 0, 2'd1, 1);
        wait_cyc(73); ifc.cmd_run = 0;
        wait_cyc(78); ifc.cfg_valid = 1; ifc.cfg_div = 2;
        wait_cyc(79); ifc.cfg_valid = 0;
        wait_cyc(89); ifc.cmd_stop = 1;
        push(90, "stop", 0, 0, 2'd0, 1);
        wait_cyc(90); ifc.cmd_stop = 0;

        // cfg_div=0 in IDLE maps to 1: toggle every cycle
        wait_cyc(91); ifc.cfg_valid = 1; ifc.cfg_div = 0;
        push(92, "div0_pending", 0, 0, 2'd0, 0);
        push(93, "div0_applied", 0, 0, 2'd0, 1);
        wait_cyc(92); ifc.cfg_valid = 0;
        wait_cyc(94); ifc.cmd_run = 1;
        push(95, "div1_run", 0, 0, 2'd1, 1);
        for (int k = 0; k < 8; k++)
            push(96 + k, "div1_toggle", (k % 2 == 0), (k % 2 == 0), 2'd1, 1);
        push(104, "cfg_on_boundary",  1, 1, 2'd1, 0);
        push(105, "apply_next_bound", 0, 0, 2'd1, 1);
        push(109, "div4_rise",        1, 1, 2'd1, 1);
        push(113, "div4_fall",        0, 0, 2'd1, 1);
        wait_cyc(95); ifc.cmd_run = 0;
        wait_cyc(103); ifc.cfg_valid = 1; ifc.cfg_div = 4;
        wait_cyc(104); ifc.cfg_valid = 0;

        // Stop and run together on a rising boundary: stop wins
        wait_cyc(116); ifc.cmd_stop = 1; ifc.cmd_run = 1;
        push(117, "stop_run_boundary", 0, 0, 2'd0, 1);
        wait_cyc(117); ifc.cmd_stop = 0; ifc.cmd_run = 0;

        // Reset during RUN with a pending divisor, then rerun at default
        wait_cyc(119); ifc.cmd_run = 1;
        push(120, "pre_rst_run",  0, 0, 2'd1, 1);
        push(124, "pre_rst_rise", 1, 1, 2'd1, 1);
        push(126, "pre_rst_pend", 1, 0, 2'd1, 0);
        push(128, "mid_reset",    0, 0, 2'd0, 1);
        push(130, "post_rst_run", 0, 0, 2'd1, 1);
        push(134, "post_rst_rise",1, 1, 2'd1, 1);
        push(138, "post_rst_fall",0, 0, 2'd1, 1);
        push(140, "final_stop",   0, 0, 2'd0, 1);
        wait_cyc(120); ifc.cmd_run = 0;
        wait_cyc(125); ifc.cfg_valid = 1; ifc.cfg_div = 7;
        wait_cyc(126); ifc.cfg_valid = 0;
        wait_cyc(127); rst_n = 1'b0;
        wait_cyc(128); rst_n = 1'b1;
        wait_cyc(129); ifc.cmd_run = 1;
        wait_cyc(130); ifc.cmd_run = 0;
        wait_cyc(139); ifc.cmd_stop = 1;
        wait_cyc(140); ifc.cmd_stop = 0;

        wait_cyc(145);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            n_cmp++; n_bad++;
            $display("FAIL %s: got no snapshot at cyc %0d, want one", e.tag, e.cyc);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
